pgas_wb_sram: RTL

- Wishbone B3 slave SRAM controller that sits directly downstream of the PGAS memory tile's Wishbone master port.
- Translates classic and incrementing-burst cycles into accesses to a single-port synchronous SRAM with 1-cycle read latency.
- Ranges outside the configured window are rejected with wb_err_o.
- Gives the tile's LSU burst throughput of one beat per cycle after the first.

---
 rtl/pgas_wb_sram.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/pgas_wb_sram.sv
// Wishbone B3 slave in front of a single-port synchronous SRAM (1-cycle read latency).
// Classic cycles take two clocks; incrementing bursts stream one beat per clock after the
// first, with linear or wrap-4/8/16 addressing. Accesses outside the window answer with err.
module pgas_wb_sram #(
    parameter int unsigned MEM_SIZE  = 32768,
    parameter logic [31:0] BASE_ADDR = 32'h0,
    localparam int unsigned AW = $clog2(MEM_SIZE) - 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   wb_adr_i,
    input  logic          wb_cyc_i,
    input  logic          wb_stb_i,
    input  logic          wb_we_i,
    input  logic [3:0]    wb_sel_i,
    input  logic [31:0]   wb_dat_i,
    input  logic [2:0]    wb_cti_i,
    input  logic [1:0]    wb_bte_i,
    output logic          wb_ack_o,
    output logic          wb_err_o,
    output logic          wb_rty_o,
    output logic [31:0]   wb_dat_o,
    output logic          sram_ce_o,
    output logic          sram_we_o,
    output logic [3:0]    sram_be_o,
    output logic [AW-1:0] sram_addr_o,
    output logic [31:0]   sram_din_o,
    input  logic [31:0]   sram_dout_i
);

    typedef enum logic [1:0] {IDLE, SINGLE, BURST, ERR} state_t;

    // Burst counter carries one extra MSB that flags "this beat has left the window".
    typedef logic [AW:0] cnt_t;

    state_t        state_q, state_d;
    cnt_t          cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [1:0]    bte_q, bte_d;

    logic [31:0]   offset;
    logic          req;
    logic          in_range;
    logic [AW-1:0] req_word;
    logic          last_beat;
    cnt_t          nxt;

    logic          ack, err, ce, swe;
    logic [3:0]    be;
    logic [AW-1:0] saddr;

    // Next burst address: low k bits wrap for wrap bursts, linear bursts simply increment
    // (and may carry into the out-of-window flag bit).
    function automatic cnt_t next_addr(input cnt_t cur, input logic [1:0] bte);
        cnt_t inc;
        cnt_t mask;
        inc = cur + cnt_t'(1);
        case (bte)
            2'b01:   mask = cnt_t'(3);
            2'b10:   mask = cnt_t'(7);
            2'b11:   mask = cnt_t'(15);
            default: mask = '1;
        endcase
        return (cur & ~mask) | (inc & mask);
    endfunction

    assign offset    = wb_adr_i - BASE_ADDR;
    assign req       = wb_cyc_i & wb_stb_i;
    assign in_range  = offset < 32'(MEM_SIZE);
    assign req_word  = offset[AW+1:2];
    assign last_beat = wb_cti_i != 3'b010;
    assign nxt       = next_addr(cnt_q, bte_q);

    // Next-state, counter and SRAM/bus strobes for the current cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        bte_d   = bte_q;
        ack     = 1'b0;
        err     = 1'b0;
        ce      = 1'b0;
        swe     = 1'b0;
        be      = wb_sel_i;
        saddr   = req_word;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (!in_range) begin
                        state_d = ERR;
                    end else begin
                        ce  = 1'b1;
                        swe = wb_we_i;
                        if (wb_cti_i == 3'b010) begin
                            state_d = BURST;
                            cnt_d   = {1'b0, req_word};
                            we_d    = wb_we_i;
                            bte_d   = wb_bte_i;
                        end else begin
                            state_d = SINGLE;
                        end
                    end
                end
            end
            SINGLE: begin
                state_d = IDLE;
                ack     = wb_cyc_i;
            end
            ERR: begin
                state_d = IDLE;
                err     = wb_cyc_i;
            end
            BURST: begin
                if (!wb_cyc_i) begin
                    state_d = IDLE;
                end else if (!wb_stb_i) begin
                    // Master wait state: keep re-reading the pending beat so it is ready on return.
                    ce    = ~cnt_q[AW];
                    be    = 4'hF;
                    saddr = cnt_q[AW-1:0];
                end else if (cnt_q[AW] || (wb_we_i != we_q)) begin
                    err     = 1'b1;
                    state_d = IDLE;
                end else begin
                    ack = 1'b1;
                    if (we_q) begin
                        ce    = 1'b1;
                        swe   = 1'b1;
                        saddr = cnt_q[AW-1:0];
                    end else begin
                        // Prefetch the following beat unless this is the last one or it leaves the window.
                        ce    = ~last_beat & ~nxt[AW];
                        be    = 4'hF;
                        saddr = nxt[AW-1:0];
                    end
                    if (last_beat) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = nxt;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and burst bookkeeping registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            bte_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            bte_q   <= bte_d;
        end
    end

    assign wb_ack_o    = ack;
    assign wb_err_o    = err;
    assign wb_rty_o    = 1'b0;
    assign wb_dat_o    = sram_dout_i;
    // Strobes are held off while reset is asserted, even if a request is on the bus.
    assign sram_ce_o   = ce & rst;
    assign sram_we_o   = swe & rst;
    assign sram_be_o   = be;
    assign sram_addr_o = saddr;
    assign sram_din_o  = wb_dat_i;

endmodule
